// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM encoding and default debounce length
// shared by alu_mode_seq and sw_debounce.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  localparam int DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser plus stability counter for
// one raw push switch; db follows raw after DEB_CYCLES stable cycles.
module sw_debounce
  import alu_pkg::*;
#(
  parameter int DEB_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mode_seq.sv
// alu_mode_seq: clocked DIP/push-switch ALU with iterative mul/div.
// Define ALU_AUTO_REFRESH_EN to re-run the current mode on DIP changes.
module alu_mode_seq
  import alu_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter int NUM_SW     = 6,
  parameter int DEB_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*OP_W-1:0]   DIP_input,
  input  logic [NUM_SW-1:0]   PUSHSW_input,
  output logic [2*OP_W-1:0]   result,
  output logic                result_valid,
  output logic                busy,
  output logic [2:0]          mode,
  output logic                flag
);

  localparam int RW = 2 * OP_W;
  localparam int CW = $clog2(OP_W + 1);

  state_t            state;
  state_t            state_nx;
  logic [RW-1:0]     dip_q1;
  logic [RW-1:0]     dip_q2;
  logic [NUM_SW-1:0] db;
  logic [NUM_SW-1:0] db_d;
  logic [NUM_SW-1:0] rise;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [OP_W-1:0]   quo;
  logic [OP_W-1:0]   rem;
  logic [RW-1:0]     acc;
  logic [CW-1:0]     it_cnt;
  logic              it_last;
  logic              trig;
  logic [2:0]        trig_op;
  logic [OP_W:0]     sum;
  logic [OP_W:0]     diff;
  logic [OP_W:0]     trial;
  logic [RW-1:0]     res_nx;
  logic              flag_nx;
`ifdef ALU_AUTO_REFRESH_EN
  logic              have_cmd;
`endif

  for (genvar k = 0; k < NUM_SW; k++) begin : g_sw
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_db (
      .clk(clk),
      .rst(rst),
      .raw(PUSHSW_input[k]),
      .db (db[k])
    );
  end

  assign rise  = db & ~db_d;
  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign diff  = {1'b0, a_q} - {1'b0, b_q};
  assign trial = {rem, a_q[it_cnt]};

  // descending scan so the lowest raised index wins
  always_comb begin
    trig    = 1'b0;
    trig_op = mode;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      if (rise[k]) begin
        trig    = 1'b1;
        trig_op = 3'(k);
      end
    end
`ifdef ALU_AUTO_REFRESH_EN
    if (!trig && have_cmd && (dip_q2 != {a_q, b_q}))
      trig = 1'b1;
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (trig)
              state_nx = is_iter(trig_op) ? CALC : DONE;
      CALC: if (it_last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    res_nx  = '0;
    flag_nx = 1'b0;
    unique case (mode)
      OP_ADD: begin
        res_nx  = RW'(sum);
        flag_nx = sum[OP_W];
      end
      OP_SUB: begin
        res_nx  = {{(OP_W-1){diff[OP_W]}}, diff};
        flag_nx = diff[OP_W];
      end
      OP_AND: res_nx = RW'(a_q & b_q);
      OP_OR:  res_nx = RW'(a_q | b_q);
      OP_XOR: res_nx = RW'(a_q ^ b_q);
      OP_MUL: res_nx = acc;
      OP_DIV: begin
        res_nx  = {quo, rem};
        flag_nx = (b_q == '0);
      end
      default: res_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dip_q1       <= '0;
      dip_q2       <= '0;
      db_d         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      quo          <= '0;
      rem          <= '0;
      acc          <= '0;
      it_cnt       <= '0;
      it_last      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      mode         <= '0;
      flag         <= 1'b0;
`ifdef ALU_AUTO_REFRESH_EN
      have_cmd     <= 1'b0;
`endif
    end else begin
      dip_q1       <= DIP_input;
      dip_q2       <= dip_q1;
      db_d         <= db;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: if (trig) begin
          a_q     <= dip_q2[RW-1:OP_W];
          b_q     <= dip_q2[OP_W-1:0];
          mode    <= trig_op;
          acc     <= '0;
          rem     <= '0;
          quo     <= '0;
          it_cnt  <= CW'(OP_W - 1);
          it_last <= 1'b0;
          busy    <= is_iter(trig_op);
`ifdef ALU_AUTO_REFRESH_EN
          have_cmd <= 1'b1;
`endif
        end
        CALC: if (it_last) begin
          busy <= 1'b0;
        end else begin
          // both iterate MSB first, bit index = it_cnt
          if (mode == OP_MUL) begin
            acc <= {acc[RW-2:0], 1'b0} +
                   (b_q[it_cnt] ? {{OP_W{1'b0}}, a_q}
                                : {RW{1'b0}});
          end else if (trial >= {1'b0, b_q}) begin
            rem         <= OP_W'(trial - {1'b0, b_q});
            quo[it_cnt] <= 1'b1;
          end else begin
            rem <= trial[OP_W-1:0];
          end
          if (it_cnt == '0) it_last <= 1'b1;
          else              it_cnt  <= it_cnt - 1'b1;
        end
        DONE: begin
          result       <= res_nx;
          flag         <= flag_nx;
          result_valid <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mode_seq.sv
// tb_alu_mode_seq: directed and random push/DIP sequences checked
// against an arithmetic model of the ALU results and timing.
module tb_alu_mode_seq;

  localparam int OP_W   = 5;
  localparam int NUM_SW = 7;
  localparam int DEB    = 16;
  localparam int RW     = 2 * OP_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [RW-1:0]     dip;
  logic [NUM_SW-1:0] sw;
  logic [RW-1:0]     result;
  logic              result_valid;
  logic              busy;
  logic [2:0]        mode;
  logic              flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mode_seq #(
    .OP_W      (OP_W),
    .NUM_SW    (NUM_SW),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DIP_input   (dip),
    .PUSHSW_input(sw),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .mode        (mode),
    .flag        (flag)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_res(int op, int a, int b);
    case (op)
      0: return a + b;
      1: return (a - b) & 'h3FF;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * b;
      6: return (b == 0) ? (31 * 32 + a) : ((a / b) * 32 + a % b);
      default: return 0;
    endcase
  endfunction

  function automatic int ref_flag(int op, int a, int b);
    case (op)
      0: return (a + b > 31) ? 1 : 0;
      1: return (a < b) ? 1 : 0;
      6: return (b == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic do_op(input string tag, input int k, input int a,
                       input int b, input int bounces, input int k2);
    int lat;
    int pulses;
    int bcyc;
    int res_at;
    int flg_at;
    int exp_lat;
    dip = RW'((a << OP_W) | b);
    repeat (16) @(posedge clk);
    #1;
    for (int j = 0; j < bounces; j++) begin
      sw[k] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sw[k] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    sw[k]  = 1'b1;
    lat    = -1;
    pulses = 0;
    bcyc   = 0;
    res_at = 0;
    flg_at = 0;
    for (int i = 1; i <= 90; i++) begin
      @(posedge clk);
      #1;
      if (k2 >= 0 && i == 2) sw[k2] = 1'b1;
      if (i == 60) begin
        sw[k] = 1'b0;
        if (k2 >= 0) sw[k2] = 1'b0;
      end
      if (busy) bcyc++;
      if (result_valid) begin
        pulses++;
        if (lat < 0) begin
          lat    = i;
          res_at = int'(result);
          flg_at = int'(flag);
        end
      end
    end
    exp_lat = (k >= 5) ? DEB + 3 + OP_W + 2 : DEB + 4;
    check({tag, ".res"},    res_at, ref_res(k, a, b));
    check({tag, ".flag"},   flg_at, ref_flag(k, a, b));
    check({tag, ".lat"},    lat,    exp_lat);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".busy"},   bcyc,   (k >= 5) ? OP_W + 1 : 0);
    check({tag, ".mode"},   mode,   k);
  endtask

  initial begin
    int lat;
    int pulses;
    int res_at;
    int k;
    int a;
    int b;
    rst = 1'b1;
    sw  = '0;
    dip = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst0.result", result, 0);
    check("rst0.valid",  result_valid, 0);
    check("rst0.busy",   busy, 0);
    check("rst0.mode",   mode, 0);
    check("rst0.flag",   flag, 0);
    rst = 1'b0;

    do_op("deb",  0, 20, 15, 5, -1);
    do_op("sub",  1, 3,  9,  0, -1);
    do_op("mul",  5, 31, 31, 0, 2);
    do_op("div",  6, 29, 4,  0, -1);
    do_op("div0", 6, 9,  0,  0, -1);

    // reset during the third CALC cycle of a multiply
    dip = RW'((31 << OP_W) | 31);
    repeat (16) @(posedge clk);
    #1;
    sw[5] = 1'b1;
    lat   = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        lat = i;
        break;
      end
    end
    check("rst.busy_start", lat, DEB + 3);
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy_mid", busy, 1);
    rst   = 1'b1;
    sw[5] = 1'b0;
    @(posedge clk);
    #1;
    check("rst.result", result, 0);
    check("rst.valid",  result_valid, 0);
    check("rst.busy",   busy, 0);
    check("rst.mode",   mode, 0);
    check("rst.flag",   flag, 0);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    check("rst.no_pulse", pulses, 0);
    do_op("post", 0, 7, 8, 0, -1);

    for (int n = 0; n < 18; n++) begin
      k = int'($urandom_range(0, NUM_SW - 1));
      a = int'($urandom_range(0, 31));
      b = (n % 5 == 0) ? 0 : int'($urandom_range(0, 31));
      do_op($sformatf("rnd%0d", n), k, a, b, 0, -1);
    end

    do_op("pre", 0, 20, 15, 0, -1);
    dip    = RW'((1 << OP_W) | 1);
    pulses = 0;
    res_at = int'(result);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        pulses++;
        res_at = int'(result);
      end
    end
`ifdef ALU_AUTO_REFRESH_EN
    check("auto.pulses", pulses, 1);
    check("auto.res",    res_at, 2);
`else
    check("auto.pulses", pulses, 0);
    check("auto.res",    res_at, 35);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
